// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request port plus the decode/execute side.
// Handshakes: a memory request is accepted in a cycle with mem_req=1 and mem_stall=0;
// a fetched word is consumed by decode in a cycle with valid=1 and stall=0.
interface fetch_if;
    logic        redirect;
    logic [15:0] target;
    logic        stall;
    logic        halt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
    logic        halted;
    logic        err;

    modport master (
        input  redirect, target, stall, halt, mem_stall, mem_done, mem_rdata,
        output mem_req, mem_addr, instr, pc_plus2, valid, halted, err
    );

    modport slave (
        output redirect, target, stall, halt, mem_stall, mem_done, mem_rdata,
        input  mem_req, mem_addr, instr, pc_plus2, valid, halted, err
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads, hands words
// plus PC+2 to decode, and applies execute's redirects, HALT and misaligned-target errors.
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0800
) (
    input  logic       clk,
    input  logic       rst,
    fetch_if.master    bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        squash_q, squash_d;
    logic        halt_pend_q, halt_pend_d;

    logic        redir_bad;
    logic        redir_ok;
    logic        halt_req;

    // A halt arriving with a redirect is on the wrong path and is ignored.
    assign redir_bad = bus.redirect & bus.target[0];
    assign redir_ok  = bus.redirect & ~bus.target[0];
    assign halt_req  = bus.halt & ~bus.redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus2_d  = pc_plus2_q;
        valid_d     = valid_q & bus.stall & ~bus.redirect;
        err_d       = err_q;
        squash_d    = squash_q;
        halt_pend_d = halt_pend_q;

        case (state_q)
            S_FETCH: begin
                if (redir_bad || halt_req) begin
                    err_d = err_q | redir_bad;
                    // An accepted request must drain before HALT is entered.
                    if (bus.mem_stall) begin
                        state_d = S_HALT;
                    end else begin
                        state_d     = S_WAIT;
                        halt_pend_d = 1'b1;
                    end
                end else begin
                    if (redir_ok) begin
                        pc_d = bus.target;
                    end
                    if (!bus.mem_stall) begin
                        state_d  = S_WAIT;
                        squash_d = redir_ok;
                    end
                end
            end
            S_WAIT: begin
                if (redir_bad || halt_req) begin
                    err_d = err_q | redir_bad;
                    if (bus.mem_done) begin
                        state_d = S_HALT;
                    end else begin
                        halt_pend_d = 1'b1;
                    end
                end else if (redir_ok) begin
                    pc_d = bus.target;
                    if (bus.mem_done) begin
                        state_d  = halt_pend_q ? S_HALT : S_FETCH;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (bus.mem_done) begin
                    squash_d = 1'b0;
                    if (halt_pend_q) begin
                        state_d = S_HALT;
                    end else if (squash_q) begin
                        state_d = S_FETCH;
                    end else begin
                        instr_d    = bus.mem_rdata;
                        pc_plus2_d = pc_q + 16'd2;
                        pc_d       = pc_q + 16'd2;
                        valid_d    = 1'b1;
                        state_d    = bus.stall ? S_HOLD : S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redir_bad || halt_req) begin
                    err_d   = err_q | redir_bad;
                    state_d = S_HALT;
                end else if (redir_ok) begin
                    pc_d    = bus.target;
                    state_d = S_FETCH;
                end else if (!bus.stall) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
            end
        endcase

        if (state_d == S_HALT) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= NOP;
            pc_plus2_q  <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus2_q  <= pc_plus2_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            squash_q    <= squash_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus.mem_req  = (state_q == S_FETCH);
    assign bus.mem_addr = pc_q;
    assign bus.instr    = valid_q ? instr_q : NOP;
    assign bus.pc_plus2 = pc_plus2_q;
    assign bus.valid    = valid_q;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.err      = err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios with literal expectations, then randomized
// episodes checked every cycle against a transaction-level model of the stage.
module tb_fetch;
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_w;

  fetch_if bus ();
  fetch_if bus_w ();

  fetch #(.RESET_PC(16'h0000), .NOP(16'h0800)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.master), .dbg_state_o(dbg_state)
  );

  fetch #(.RESET_PC(16'hFFFE), .NOP(16'h0800)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus_w.master), .dbg_state_o(dbg_state_w)
  );

  int n_chk = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1111;
      16'h0002: mem_word = 16'h2222;
      16'h0004: mem_word = 16'h3333;
      16'hFFFE: mem_word = 16'h7E57;
      default:  mem_word = {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
    endcase
  endfunction

  // ---------------- memory models ----------------
  bit          rand_mode = 1'b0;
  int          cfg_k = 1;
  int          cfg_stall_n = 0;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_lat;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      mem_busy      = 1'b0;
      mem_cnt       = 0;
      bus.mem_done  = 1'b0;
      bus.mem_stall = 1'b0;
    end else begin
      bus.mem_done = 1'b0;
      if (mem_busy) begin
        chk1("mem_single_outstanding", bus.mem_req, 1'b0);
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = mem_word(mem_lat);
          mem_busy      = 1'b0;
        end
      end
      if (rand_mode) begin
        bus.mem_stall = ($urandom_range(0, 3) == 0);
      end else if (bus.mem_req && cfg_stall_n > 0) begin
        bus.mem_stall = 1'b1;
        cfg_stall_n--;
      end else begin
        bus.mem_stall = 1'b0;
      end
      if (!mem_busy && !bus.mem_done && bus.mem_req && !bus.mem_stall) begin
        mem_busy = 1'b1;
        mem_lat  = bus.mem_addr;
        mem_cnt  = rand_mode ? int'($urandom_range(1, 4)) : cfg_k;
      end
    end
  end

  bit          memw_busy;
  logic [15:0] memw_lat;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      memw_busy       = 1'b0;
      bus_w.mem_done  = 1'b0;
      bus_w.mem_stall = 1'b0;
    end else begin
      bus_w.mem_done = 1'b0;
      if (memw_busy) begin
        bus_w.mem_done  = 1'b1;
        bus_w.mem_rdata = mem_word(memw_lat);
        memw_busy       = 1'b0;
      end else if (bus_w.mem_req) begin
        memw_busy = 1'b1;
        memw_lat  = bus_w.mem_addr;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [15:0] m_pc, m_instr, m_pp2;
  bit m_wait, m_drop, m_stop, m_halted, m_err, m_hold, m_valid;
  bit e_req, e_bad, e_red, e_hlt, e_acc, e_done, e_still, e_lands;

  always @(negedge clk) begin
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0800; m_pp2 = 16'h0000;
      m_wait = 0; m_drop = 0; m_stop = 0; m_halted = 0; m_err = 0; m_hold = 0; m_valid = 0;
    end else begin
      // Fetch is idle-ready to request unless stopped, waiting on memory, or parked on decode.
      e_req = !m_halted && !m_wait && !m_hold;
      chk1("model_mem_req", bus.mem_req, e_req);
      if (e_req) chk16("model_mem_addr", bus.mem_addr, m_pc);
      chk1("model_valid", bus.valid, m_valid);
      chk16("model_instr", bus.instr, m_valid ? m_instr : 16'h0800);
      chk16("model_pc_plus2", bus.pc_plus2, m_pp2);
      chk1("model_halted", bus.halted, m_halted);
      chk1("model_err", bus.err, m_err);

      if (!m_halted) begin
        e_bad   = bus.redirect && bus.target[0];
        e_red   = bus.redirect && !bus.target[0];
        e_hlt   = bus.halt && !bus.redirect;
        e_acc   = e_req && !bus.mem_stall;
        e_done  = m_wait && bus.mem_done;
        e_still = (m_wait && !bus.mem_done) || e_acc;
        e_lands = e_done && !m_drop && !m_stop && !bus.redirect && !e_hlt;
        if (e_lands) begin
          m_instr = mem_word(m_pc);
          m_pp2   = m_pc + 16'd2;
          m_pc    = m_pc + 16'd2;
          m_valid = 1;
          m_hold  = bus.stall;
        end else begin
          m_valid = m_valid && bus.stall && !bus.redirect;
          if (m_hold && (!bus.stall || bus.redirect || e_hlt)) m_hold = 0;
        end
        if (e_red) m_pc = bus.target;
        if (e_bad) m_err = 1;
        m_drop = e_red ? e_still : (e_done ? 1'b0 : m_drop);
        m_stop = m_stop || e_bad || e_hlt;
        m_wait = e_still;
        if (m_stop && !e_still) begin
          m_halted = 1; m_valid = 0; m_hold = 0;
        end
      end
    end
  end

  // ---------------- driver / directed + random stimulus ----------------
  logic [15:0] rt;

  initial begin
    rst = 1'b1;
    bus.redirect = 0; bus.target = 16'h0000; bus.stall = 0; bus.halt = 0;
    bus.mem_stall = 0; bus.mem_done = 0; bus.mem_rdata = 16'h0000;
    bus_w.redirect = 0; bus_w.target = 16'h0000; bus_w.stall = 0; bus_w.halt = 0;
    bus_w.mem_stall = 0; bus_w.mem_done = 0; bus_w.mem_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      bus.stall    = (c >= 8 && c <= 11);
      bus.redirect = (c == 14 || c == 20 || c == 22 || c == 25);
      bus.target   = (c == 14) ? 16'h0100 : (c == 20) ? 16'h0040 :
                     (c == 22) ? 16'h0080 : 16'h0033;
      bus.halt     = (c == 22);
      bus_w.halt   = (c == 3);
      @(negedge clk);
      case (c)
        0: begin
          chk1("rst_mem_req", bus.mem_req, 1'b1);
          chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
          chk1("rst_valid", bus.valid, 1'b0);
          chk16("rst_instr_nop", bus.instr, 16'h0800);
          chk16("rst_pc_plus2", bus.pc_plus2, 16'h0000);
          chk1("rst_halted", bus.halted, 1'b0);
          chk1("rst_err", bus.err, 1'b0);
          chk16("wrap_first_addr", bus_w.mem_addr, 16'hFFFE);
        end
        1: chk1("seq_wait_no_req", bus.mem_req, 1'b0);
        2: begin
          chk1("seq_w1_valid", bus.valid, 1'b1);
          chk16("seq_w1_instr", bus.instr, 16'h1111);
          chk16("seq_w1_pc_plus2", bus.pc_plus2, 16'h0002);
          chk16("seq_second_addr", bus.mem_addr, 16'h0002);
          chk16("wrap_pc_plus2", bus_w.pc_plus2, 16'h0000);
          chk16("wrap_instr", bus_w.instr, 16'h7E57);
          chk16("wrap_second_addr", bus_w.mem_addr, 16'h0000);
          chk1("wrap_no_err", bus_w.err, 1'b0);
        end
        3: begin
          chk1("seq_valid_cleared", bus.valid, 1'b0);
          chk1("wrap_halt_waits_done", bus_w.halted, 1'b0);
        end
        4: begin
          chk16("seq_w2_instr", bus.instr, 16'h2222);
          chk16("seq_w2_pc_plus2", bus.pc_plus2, 16'h0004);
          chk1("wrap_halted", bus_w.halted, 1'b1);
          chk1("wrap_halt_valid", bus_w.valid, 1'b0);
          chk1("wrap_halt_no_req", bus_w.mem_req, 1'b0);
        end
        6, 7: chk16("bp_addr_held", bus.mem_addr, 16'h0004);
        8:  chk1("bp_accepted_wait", bus.mem_req, 1'b0);
        10: begin
          chk1("hold_valid_frozen", bus.valid, 1'b1);
          chk16("hold_instr_frozen", bus.instr, 16'h3333);
          chk1("hold_no_req", bus.mem_req, 1'b0);
        end
        12: chk1("hold_still_no_req", bus.mem_req, 1'b0);
        13: begin
          chk16("hold_release_addr", bus.mem_addr, 16'h0006);
          chk1("hold_release_valid", bus.valid, 1'b0);
        end
        16: chk1("squash_no_valid", bus.valid, 1'b0);
        17: begin
          chk1("squash_no_valid_after", bus.valid, 1'b0);
          chk1("squash_req", bus.mem_req, 1'b1);
          chk16("squash_target_addr", bus.mem_addr, 16'h0100);
        end
        21: begin
          chk1("simul_valid_low", bus.valid, 1'b0);
          chk16("simul_target_addr", bus.mem_addr, 16'h0040);
        end
        23: chk1("halt_redirect_ignored", bus.halted, 1'b0);
        25: begin
          chk16("halt_redirect_addr", bus.mem_addr, 16'h0080);
          chk1("halt_redirect_not_halted", bus.halted, 1'b0);
        end
        26, 29: begin
          chk1("misalign_err", bus.err, 1'b1);
          chk1("misalign_halted", bus.halted, 1'b1);
          chk1("misalign_no_req", bus.mem_req, 1'b0);
        end
        default: begin
        end
      endcase
      if (c == 3)  cfg_stall_n = 3;
      if (c == 24) cfg_stall_n = 1;
      cfg_k = (c >= 12) ? 3 : 1;
    end

    // Randomized episodes; each starts with a reset that may land mid-request.
    rand_mode  = 1'b1;
    bus.halt   = 0;
    bus_w.halt = 0;
    for (int ep = 0; ep < 8; ep++) begin
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (c > 0) begin
          @(posedge clk);
          #1;
        end
        rt = 16'($urandom_range(0, 65535));
        rt[0] = ($urandom_range(0, 39) == 0);
        bus.target   = rt;
        bus.redirect = ($urandom_range(0, 11) == 0);
        bus.stall    = ($urandom_range(0, 2) == 0);
        bus.halt     = ($urandom_range(0, 199) == 0);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage directly upstream of `execute`. It holds the architectural PC and fetches 16-bit instructions from a single-outstanding-request instruction memory. It hands each instruction to decode together with PC+2, which is the `PC` value `execute` adds to the branch/jump immediate. It applies `execute`'s `nextPC` redirects, stops on HALT, and flags misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP, 16'h0800, instruction word driven on `instr` while `valid`=0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- redirect  in  1  taken branch/jump/jumpReg resolved in execute this cycle.
- target  in  16  execute `nextPC`; sampled only when `redirect`=1.
- stall  in  1  decode cannot accept; hold the current output.
- halt  in  1  decode has a HALT instruction.
- mem_req  out  1  request instruction read.
- mem_addr  out  16  read address; equals PC whenever `mem_req`=1.
- mem_stall  in  1  memory did not accept the request this cycle; retry.
- mem_done  in  1  read data valid this cycle.
- mem_rdata  in  16  instruction word; sampled when `mem_done`=1.
- instr  out  16  fetched instruction (registered).
- pc_plus2  out  16  address of `instr` + 2 (registered).
- valid  out  1  `instr`/`pc_plus2` are meaningful.
- halted  out  1  fetch permanently stopped.
- err  out  1  misaligned redirect; sticky.

## Operation
- The state machine has four states: FETCH, WAIT, HOLD, HALT.
- **FETCH:** `mem_req`=1, `mem_addr`=pc.
  - `mem_stall`=1: stay in FETCH and retry the same address next cycle.
  - Otherwise go to WAIT.
- **WAIT:** `mem_req`=0 while waiting for `mem_done`.
  - On `mem_done` with `stall`=0: latch `instr`←`mem_rdata`, `pc_plus2`←pc+2, `valid`←1, pc←pc+2, go to FETCH.
  - On `mem_done` with `stall`=1: latch the same values, go to HOLD.
- **HOLD:** `valid` and the outputs stay frozen and no request is issued. When `stall` falls, go to FETCH. `valid` clears on the cycle the consumer accepts (`valid`=1 & `stall`=0), unless a new word lands that same edge.
- **Redirect** (any state except HALT): pc←target.
  - `valid` clears next edge.
  - In FETCH the next cycle's `mem_addr` is the target.
  - In WAIT a squash bit is set. The response for the outstanding request is dropped when `mem_done` arrives, with no `valid` and no pc increment. The FSM then returns to FETCH with pc=target. A new request is never issued before the outstanding `mem_done`.
  - In HOLD: go to FETCH.
- **Misaligned redirect:** `redirect`=1 with `target[0]`=1 sets `err`=1 (sticky) and enters HALT. If a request is outstanding, HALT waits for its `mem_done` and discards the data.
- **Halt:** `halt`=1 without `redirect` stops new requests. Any outstanding `mem_done` is absorbed and discarded, then the FSM enters HALT with `halted`=1 and `valid`=0. HALT exits only on `rst`.
- **Arithmetic:** PC arithmetic is 16-bit modulo. 16'hFFFE+2 = 16'h0000, with no error.

## Timing
- **Reset values:** pc=RESET_PC, state=FETCH, `instr`=NOP, `pc_plus2`=0, `valid`=0, `halted`=0, `err`=0, squash=0.
  - `mem_req`=1 in the first cycle after `rst` falls.
  - `rst` asserted mid-request abandons that request. The bench must also reset the memory.
- **Latency:** request accepted at cycle N, `mem_done` at N+k (k≥1), `valid` rises at N+k+1, next request issued at N+k+1.
  - Throughput is one instruction per k+1 cycles with no stalls.
- **Redirect timing:** `redirect` at cycle R gives `mem_addr`=target at R+1 if idle, otherwise on the cycle after the squashed `mem_done`.
- **Same-cycle priority:** rst > misaligned redirect > redirect > halt > mem_done/stall.
  - `redirect` together with `mem_done` in WAIT: data dropped, pc=target, FETCH next.
  - `redirect` together with `stall` in HOLD: redirect wins, `valid`=0 next.
  - `halt` together with `redirect`: the halt is on the wrong path and is ignored.
- **`err` and `halted`:** rise on the edge after their cause and stay high until `rst`.

## Test plan
- Sequential fetch: reset, memory k=1 returning 0x1111, 0x2222 → `mem_addr` 0x0000, 0x0002 issued 2 cycles apart; `valid` pulses with `instr`=0x1111/`pc_plus2`=0x0002, then 0x2222/0x0004.
- Backpressure: `mem_stall`=1 for 3 cycles at addr 0x0004 → `mem_addr` held at 0x0004 and accepted on cycle 4. Then `stall`=1 for 4 cycles after `mem_done` → `instr` and `valid` frozen, no `mem_req` until `stall` falls.
- Squash: k=3, `redirect`=1 with target 0x0100 one cycle after the request → the stale `mem_done` produces no `valid`, and the next `mem_addr` is 0x0100.
- Simultaneous: `redirect` (target 0x0040) on the same cycle as `mem_done` → `valid` stays 0, next `mem_addr`=0x0040. Also `halt`+`redirect` together → `halted` stays 0.
- Misaligned: `redirect` with target 0x0033 → `err`=1 and `halted`=1 next cycle, no further `mem_req`, and both persist until `rst`.
- Wrap and halt: RESET_PC=0xFFFE → second `mem_addr`=0x0000 and `pc_plus2`=0x0000 for the first word, `err`=0. Then `halt`=1 → `halted`=1 after the outstanding `mem_done`, `valid`=0.
